// File: rtl/spr_compositor_multi_if.sv
// Pixel timing, shadow-config, pattern-ROM and composited-output bundle for spr_compositor_multi.
interface spr_compositor_multi_if #(
  parameter int NUM_SPR    = 4,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int FRAME_BITS = 2,
  parameter int CW         = 9,
  parameter int AW         = FRAME_BITS + $clog2(SPR_W) + $clog2(SPR_H)
);
  logic [9:0]            pixel_x;
  logic [9:0]            pixel_y;
  logic                  vga_block;
  logic                  vga_end;
  logic [CW-1:0]         vram_dat;
  logic                  cfg_we;
  logic [2:0]            cfg_sel;
  logic [9:0]            cfg_x;
  logic [9:0]            cfg_y;
  logic                  cfg_en;
  logic                  cfg_flip;
  logic [FRAME_BITS-1:0] cfg_frame;
  logic [NUM_SPR*AW-1:0] spr_rom_adr;
  logic [NUM_SPR*CW-1:0] spr_rom_dat;
  logic [CW-1:0]         vga_dat;
  logic [NUM_SPR-1:0]    coll_flags;
  logic                  coll_valid;

  modport master (
    output pixel_x, pixel_y, vga_block, vga_end, vram_dat,
    output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, cfg_flip, cfg_frame,
    output spr_rom_dat,
    input  spr_rom_adr, vga_dat, coll_flags, coll_valid
  );

  modport slave (
    input  pixel_x, pixel_y, vga_block, vga_end, vram_dat,
    input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, cfg_flip, cfg_frame,
    input  spr_rom_dat,
    output spr_rom_adr, vga_dat, coll_flags, coll_valid
  );
endinterface

// File: rtl/spr_compositor_multi.sv
// Overlays NUM_SPR colour-keyed sprites on VRAM background, lowest index on top, per-frame collisions.
// Latency: pixel_x at t -> vga_dat at t+2; free-running with pixel timing, no backpressure.
module spr_compositor_multi #(
  parameter int            NUM_SPR    = 4,
  parameter int            SPR_W      = 32,
  parameter int            SPR_H      = 32,
  parameter int            FRAME_BITS = 2,
  parameter int            CW         = 9,
  parameter logic [CW-1:0] TRANSP     = '0
) (
  input logic               clk_25mhz,
  input logic               RST_N,
  spr_compositor_multi_if.slave bus
);
  localparam int LW = $clog2(SPR_W);
  localparam int LH = $clog2(SPR_H);
  localparam int AW = FRAME_BITS + LW + LH;

  typedef struct packed {
    logic                  en;
    logic                  flip;
    logic [FRAME_BITS-1:0] frame;
    logic [9:0]            x;
    logic [9:0]            y;
  } spr_cfg_t;

  spr_cfg_t shadow     [NUM_SPR];
  spr_cfg_t shadow_nxt [NUM_SPR];
  spr_cfg_t active     [NUM_SPR];

  logic [10:0]           dx_w [NUM_SPR];
  logic [10:0]           dy_w [NUM_SPR];
  logic [LW-1:0]         dx_p;
  logic [NUM_SPR-1:0]    hit;
  logic [NUM_SPR*AW-1:0] rom_adr;

  logic [NUM_SPR-1:0]    hit_d;
  logic                  vblk_d;
  logic [NUM_SPR-1:0]    opaque;
  logic [NUM_SPR-1:0]    coll_now;
  logic [3:0]            n_opq;
  logic [CW-1:0]         rom_c;
  logic [CW-1:0]         pix;

  logic [CW-1:0]         vga_dat_q;
  logic [NUM_SPR-1:0]    coll_acc;
  logic [NUM_SPR-1:0]    coll_flags_q;
  logic                  coll_valid_q;

  // A write landing on the vga_end cycle must also reach the active copy.
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      shadow_nxt[i] = shadow[i];
      if (bus.cfg_we && int'(bus.cfg_sel) == i) begin
        shadow_nxt[i].en    = bus.cfg_en;
        shadow_nxt[i].flip  = bus.cfg_flip;
        shadow_nxt[i].frame = bus.cfg_frame;
        shadow_nxt[i].x     = bus.cfg_x;
        shadow_nxt[i].y     = bus.cfg_y;
      end
    end
  end

  // 11-bit differences: pixel left of / above the sprite sets bit 10 and misses, so no wrap.
  always_comb begin
    hit     = '0;
    rom_adr = '0;
    dx_p    = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      dx_w[i] = {1'b0, bus.pixel_x} - {1'b0, active[i].x};
      dy_w[i] = {1'b0, bus.pixel_y} - {1'b0, active[i].y};
      hit[i]  = active[i].en && bus.vga_block &&
                (dx_w[i] < 11'(SPR_W)) && (dy_w[i] < 11'(SPR_H));
      dx_p    = active[i].flip ? ~dx_w[i][LW-1:0] : dx_w[i][LW-1:0];
      if (hit[i])
        rom_adr[i*AW +: AW] = {active[i].frame, dy_w[i][LH-1:0], dx_p};
    end
  end

  assign bus.spr_rom_adr = rom_adr;

  // Scan from highest index down so the lowest opaque channel wins.
  always_comb begin
    opaque = '0;
    n_opq  = '0;
    rom_c  = '0;
    pix    = bus.vram_dat;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      rom_c = bus.spr_rom_dat[i*CW +: CW];
      if (hit_d[i] && rom_c != TRANSP) begin
        opaque[i] = 1'b1;
        pix       = rom_c;
        n_opq     = n_opq + 4'd1;
      end
    end
    coll_now = (n_opq >= 4'd2) ? opaque : '0;
  end

  always_ff @(posedge clk_25mhz or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      hit_d        <= '0;
      vblk_d       <= 1'b0;
      vga_dat_q    <= '0;
      coll_acc     <= '0;
      coll_flags_q <= '0;
      coll_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (bus.vga_end)
          active[i] <= shadow_nxt[i];
      end
      hit_d        <= hit;
      vblk_d       <= bus.vga_block;
      vga_dat_q    <= vblk_d ? pix : '0;
      coll_valid_q <= bus.vga_end;
      if (bus.vga_end) begin
        coll_flags_q <= coll_acc | coll_now;
        coll_acc     <= '0;
      end else begin
        coll_acc     <= coll_acc | coll_now;
      end
    end
  end

  assign bus.vga_dat    = vga_dat_q;
  assign bus.coll_flags = coll_flags_q;
  assign bus.coll_valid = coll_valid_q;
endmodule

// File: tb/tb_spr_compositor_multi.sv
// Directed bench for spr_compositor_multi: pixel-level reference model plus literal spot checks.
module tb_spr_compositor_multi;
  logic clk = 1'b0;
  logic rst_n;
  always #20 clk = ~clk;

  spr_compositor_multi_if #(.NUM_SPR(4), .SPR_W(32), .SPR_H(32), .FRAME_BITS(2), .CW(9)) bus();

  spr_compositor_multi #(.NUM_SPR(4), .SPR_W(32), .SPR_H(32), .FRAME_BITS(2), .CW(9), .TRANSP(9'd0))
    dut (.clk_25mhz(clk), .RST_N(rst_n), .bus(bus));

  typedef struct {bit en; bit flip; int x; int y; int frame;} cfg_t;
  typedef struct {bit blk; int px; int py; logic [8:0] col;} pe_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_cv  = 0;
  int         cv0;
  int         mode [4];
  logic [8:0] sol  [4];
  cfg_t       m_sh [4];
  cfg_t       m_act[4];
  pe_t        e0, e1;
  logic [3:0] acc, coll_d, flags_q, mcm;
  logic       end_d;
  logic [8:0] mc;
  logic [8:0] seen [int];

  // Pattern content by (channel, frame, row, column): 0 solid, 1 ramp tagged with frame, 2 left half clear.
  function automatic logic [8:0] rom_pat(int ch, int frame, int dy, int dx);
    logic [1:0] f;
    logic [4:0] d;
    f = 2'(frame);
    d = 5'(dx);
    case (mode[ch])
      1:       return {f, 2'b00, d};
      2:       return (dx < 16) ? 9'd0 : 9'h0AA;
      default: return sol[ch];
    endcase
  endfunction

  function automatic logic [8:0] vram_fn(int x, int y);
    return 9'((x * 7 + y * 13) ^ 'hA5);
  endfunction

  function automatic void model_px(input bit blk, input int px, input int py,
                                   output logic [8:0] col, output logic [3:0] coll);
    int cnt, sdx, pdx;
    logic [3:0] m;
    logic [8:0] c;
    cnt = 0;
    m   = '0;
    col = blk ? vram_fn(px, py) : 9'd0;
    if (blk) begin
      for (int ch = 3; ch >= 0; ch--) begin
        if (m_act[ch].en && px >= m_act[ch].x && px < m_act[ch].x + 32 &&
            py >= m_act[ch].y && py < m_act[ch].y + 32) begin
          sdx = px - m_act[ch].x;
          pdx = m_act[ch].flip ? 31 - sdx : sdx;
          c   = rom_pat(ch, m_act[ch].frame, py - m_act[ch].y, pdx);
          if (c != 9'd0) begin
            col   = c;
            cnt++;
            m[ch] = 1'b1;
          end
        end
      end
    end
    coll = (cnt >= 2) ? m : 4'd0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_px(string name, int x, int y, logic [8:0] exp);
    if (seen.exists(y * 1024 + x)) chk(name, 32'(seen[y * 1024 + x]), 32'(exp));
    else chk(name, 32'hDEAD, 32'(exp));
  endtask

  // Behavioural ROM and VRAM, both with one cycle of read latency.
  always @(posedge clk) begin
    bus.vram_dat <= vram_fn(int'(bus.pixel_x), int'(bus.pixel_y));
    for (int ch = 0; ch < 4; ch++)
      bus.spr_rom_dat[ch*9 +: 9] <= rom_pat(ch, int'(bus.spr_rom_adr[ch*12+10 +: 2]),
                                            int'(bus.spr_rom_adr[ch*12+5 +: 5]),
                                            int'(bus.spr_rom_adr[ch*12 +: 5]));
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vga_dat", 32'(bus.vga_dat), 32'd0);
      chk("rst_coll_flags", 32'(bus.coll_flags), 32'd0);
      chk("rst_coll_valid", 32'(bus.coll_valid), 32'd0);
      for (int ch = 0; ch < 4; ch++) begin
        m_sh[ch]  = '{default: 0};
        m_act[ch] = '{default: 0};
      end
      e0      = '{default: 0};
      e1      = '{default: 0};
      acc     = '0;
      coll_d  = '0;
      flags_q = '0;
      end_d   = 1'b0;
    end else begin
      chk("vga_dat", 32'(bus.vga_dat), 32'(e1.col));
      if (e1.blk) seen[e1.py * 1024 + e1.px] = bus.vga_dat;
      chk("coll_valid", 32'(bus.coll_valid), 32'(end_d));
      chk("coll_flags", 32'(bus.coll_flags), 32'(flags_q));
      if (bus.coll_valid) n_cv++;
      end_d = bus.vga_end;
      if (bus.vga_end) begin
        flags_q = acc | coll_d;
        acc     = '0;
      end else begin
        acc = acc | coll_d;
      end
      model_px(bus.vga_block, int'(bus.pixel_x), int'(bus.pixel_y), mc, mcm);
      e1     = e0;
      e0     = '{blk: bus.vga_block, px: int'(bus.pixel_x), py: int'(bus.pixel_y), col: mc};
      coll_d = mcm;
      if (bus.cfg_we && bus.cfg_sel < 3'd4)
        m_sh[bus.cfg_sel] = '{en: bus.cfg_en, flip: bus.cfg_flip, x: int'(bus.cfg_x),
                              y: int'(bus.cfg_y), frame: int'(bus.cfg_frame)};
      if (bus.vga_end) m_act = m_sh;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(int x0, int x1, int y0, int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        bus.pixel_x   = 10'(x);
        bus.pixel_y   = 10'(y);
        bus.vga_block = 1'b1;
        step();
      end
    bus.vga_block = 1'b0;
  endtask

  task automatic end_frame();
    bus.vga_block = 1'b0;
    repeat (3) step();
    bus.vga_end = 1'b1;
    step();
    bus.vga_end = 1'b0;
    repeat (2) step();
  endtask

  task automatic set_cfg(int sel, int x, int y, bit en, bit flip, int frame);
    bus.cfg_sel   = 3'(sel);
    bus.cfg_x     = 10'(x);
    bus.cfg_y     = 10'(y);
    bus.cfg_en    = en;
    bus.cfg_flip  = flip;
    bus.cfg_frame = 2'(frame);
  endtask

  task automatic cfg(int sel, int x, int y, bit en, bit flip, int frame);
    set_cfg(sel, x, y, en, flip, frame);
    bus.cfg_we = 1'b1;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic probe(string name, int x, int y, int ch, logic [11:0] exp);
    bus.pixel_x   = 10'(x);
    bus.pixel_y   = 10'(y);
    bus.vga_block = 1'b1;
    #4;
    chk(name, 32'(bus.spr_rom_adr[ch*12 +: 12]), 32'(exp));
    step();
    bus.vga_block = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.vga_block = 1'b0; bus.vga_end = 1'b0;
    bus.cfg_we = 1'b0;
    set_cfg(0, 0, 0, 1'b0, 1'b0, 0);
    for (int ch = 0; ch < 4; ch++) begin
      mode[ch] = 0;
      sol[ch]  = 9'd0;
    end
    step();
    // T1: pixels streaming while held in reset, then all channels off shows plain VRAM.
    scan(0, 5, 0, 0);
    rst_n = 1'b1;
    scan(0, 15, 0, 3);
    end_frame();
    end_frame();
    chk_px("t1_bg", 5, 2, vram_fn(5, 2));
    chk("t1_no_coll", 32'(bus.coll_flags), 32'd0);

    // T2: single solid sprite, edges and ROM addressing.
    sol[0] = 9'h1C0;
    cfg(0, 100, 50, 1'b1, 1'b0, 0);
    end_frame();
    scan(98, 133, 49, 50);
    scan(98, 133, 81, 82);
    probe("t2_adr_tl", 100, 50, 0, 12'h000);
    probe("t2_adr_br", 131, 81, 0, 12'h3FF);
    probe("t2_adr_miss", 99, 50, 0, 12'h000);
    end_frame();
    chk_px("t2_tl", 100, 50, 9'h1C0);
    chk_px("t2_br", 131, 81, 9'h1C0);
    chk_px("t2_left", 99, 50, vram_fn(99, 50));
    chk_px("t2_right", 132, 50, vram_fn(132, 50));
    chk_px("t2_above", 100, 49, vram_fn(100, 49));
    chk_px("t2_below", 100, 82, vram_fn(100, 82));

    // T3: mirrored ramp on channel 1, animation frame 2.
    mode[1] = 1;
    cfg(1, 300, 200, 1'b1, 1'b1, 2);
    end_frame();
    scan(298, 333, 200, 201);
    probe("t3_adr", 300, 200, 1, 12'h81F);
    end_frame();
    chk_px("t3_flip5", 305, 200, 9'h11A);
    chk_px("t3_flip0", 300, 200, 9'h11F);
    chk_px("t3_flip31", 331, 200, 9'h100);

    // T4: overlap of ch0 (left half clear) over ch2 (solid).
    mode[0] = 2;
    sol[2]  = 9'h055;
    cfg(1, 300, 200, 1'b0, 1'b1, 2);
    cfg(0, 500, 100, 1'b1, 1'b0, 0);
    cfg(2, 510, 100, 1'b1, 1'b0, 0);
    end_frame();
    scan(495, 545, 100, 101);
    cv0 = n_cv;
    end_frame();
    chk("t4_flags", 32'(bus.coll_flags), 32'h5);
    chk("t4_cv_pulses", 32'(n_cv - cv0), 32'd1);
    chk_px("t4_transp_bg", 505, 100, vram_fn(505, 100));
    chk_px("t4_ch2_thru", 512, 100, 9'h055);
    chk_px("t4_ch0_top", 520, 100, 9'h0AA);
    chk_px("t4_ch2_only", 540, 100, 9'h055);
    cfg(2, 600, 100, 1'b1, 1'b0, 0);
    end_frame();
    chk("t4_flags_clr", 32'(bus.coll_flags), 32'd0);

    // T5: shadow registers only take effect at vga_end.
    cfg(2, 600, 100, 1'b0, 1'b0, 0);
    mode[0] = 0;
    cfg(0, 100, 50, 1'b1, 1'b0, 0);
    end_frame();
    scan(98, 133, 50, 50);
    cfg(0, 200, 50, 1'b1, 1'b0, 0);
    scan(98, 133, 51, 51);
    end_frame();
    chk_px("t5_nochange", 100, 51, 9'h1C0);
    chk_px("t5_nochange_r", 132, 51, vram_fn(132, 51));
    scan(98, 101, 50, 50);
    scan(198, 233, 50, 50);
    bus.vga_block = 1'b0;
    repeat (3) step();
    set_cfg(0, 300, 50, 1'b1, 1'b0, 0);
    bus.cfg_we  = 1'b1;
    bus.vga_end = 1'b1;
    step();
    bus.cfg_we  = 1'b0;
    bus.vga_end = 1'b0;
    repeat (2) step();
    chk_px("t5_old_gone", 100, 50, vram_fn(100, 50));
    chk_px("t5_moved", 200, 50, 9'h1C0);
    chk_px("t5_moved_r", 232, 50, vram_fn(232, 50));
    scan(298, 301, 50, 50);
    scan(198, 201, 50, 50);
    end_frame();
    chk_px("t5_end_wr", 300, 50, 9'h1C0);
    chk_px("t5_end_left", 299, 50, vram_fn(299, 50));
    chk_px("t5_end_old", 200, 50, vram_fn(200, 50));

    // T6: right-edge clipping without wrap, out-of-range channel select ignored.
    sol[3] = 9'h0F0;
    cfg(3, 1010, 60, 1'b1, 1'b0, 0);
    cfg(7, 0, 60, 1'b1, 1'b0, 0);
    end_frame();
    scan(1005, 1023, 60, 60);
    scan(0, 20, 60, 60);
    end_frame();
    chk_px("t6_start", 1010, 60, 9'h0F0);
    chk_px("t6_clip", 1023, 60, 9'h0F0);
    chk_px("t6_before", 1009, 60, vram_fn(1009, 60));
    chk_px("t6_nowrap", 5, 60, vram_fn(5, 60));

    // T7: reset mid-frame clears configuration instantly.
    scan(1008, 1011, 60, 60);
    repeat (2) step();
    bus.pixel_x   = 10'd1012;
    bus.pixel_y   = 10'd60;
    bus.vga_block = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    scan(1012, 1015, 60, 60);
    end_frame();
    chk_px("t7_pre_rst", 1010, 60, 9'h0F0);
    chk_px("t7_post_rst", 1012, 60, vram_fn(1012, 60));
    chk("t7_flags", 32'(bus.coll_flags), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
